conv_encoder: RTL and testbench

Rate-1/2, constraint-length-4 (8-state) convolutional encoder. It produces the 2-bit coded symbols consumed by the Viterbi decoder's `d_in`. Input bits arrive on a valid/ready stream and frames are zero-terminated with 3 tail bits, so every frame ends in state 0. Frames are capped so that data plus tail fits one 1024-symbol trellis memory bank.

---
 rtl/conv_encoder.sv | 155 +++++++++++++++
 tb/tb_conv_encoder.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_encoder.sv
// rtl/conv_encoder.sv - rate-1/2 K=4 convolutional encoder with zero-tail framing
// Valid/ready bit stream in, single-entry {d_out, out_last} symbol register out.
module conv_encoder #(
   parameter logic [3:0] G0       = 4'b1111,
   parameter logic [3:0] G1       = 4'b1101,
   parameter int         MAX_BITS = 1021
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       clear,
   input  logic       in_valid,
   output logic       in_ready,
   input  logic       in_bit,
   input  logic       in_last,
   output logic       out_valid,
   input  logic       out_ready,
   output logic [1:0] d_out,
   output logic       out_last,
   output logic       busy,
   output logic       overflow,
   output logic [9:0] sym_cnt
);

   localparam int CW = $clog2(MAX_BITS + 1);

   typedef enum logic [1:0] {IDLE, DATA, TAIL} state_t;

   state_t          state_q, state_d;
   logic [2:0]      s_q, s_d;
   logic [CW-1:0]   bit_cnt_q, bit_cnt_d;
   logic [1:0]      tail_cnt_q, tail_cnt_d;
   logic [9:0]      sym_cnt_q, sym_cnt_d;
   logic            out_valid_q, out_valid_d;
   logic            out_last_q, out_last_d;
   logic [1:0]      d_out_q, d_out_d;
   logic            overflow_q, overflow_d;

   logic            slot_free;
   logic            in_ready_c;
   logic            accept;
   logic            load;
   logic            load_bit;
   logic            load_last;
   logic [CW-1:0]   bit_next;
   logic            hit_max;
   logic [3:0]      win;

   always_comb begin
      state_d     = state_q;
      s_d         = s_q;
      bit_cnt_d   = bit_cnt_q;
      tail_cnt_d  = tail_cnt_q;
      sym_cnt_d   = sym_cnt_q;
      out_valid_d = out_valid_q;
      out_last_d  = out_last_q;
      d_out_d     = d_out_q;
      overflow_d  = overflow_q;
      load        = 1'b0;
      load_bit    = 1'b0;
      load_last   = 1'b0;

      slot_free  = !out_valid_q || out_ready;
      in_ready_c = slot_free && (state_q != TAIL);
      accept     = in_valid && in_ready_c;
      bit_next   = (state_q == IDLE) ? CW'(1) : bit_cnt_q + CW'(1);
      hit_max    = (bit_next == CW'(MAX_BITS));

      if (slot_free) begin
         out_valid_d = 1'b0;
         out_last_d  = 1'b0;
      end

      case (state_q)
         IDLE, DATA: begin
            if (accept) begin
               load      = 1'b1;
               load_bit  = in_bit;
               bit_cnt_d = bit_next;
               sym_cnt_d = (state_q == IDLE) ? 10'd1 : sym_cnt_q + 10'd1;
               if (state_q == IDLE) overflow_d = 1'b0;
               if (hit_max && !in_last) overflow_d = 1'b1;
               state_d   = (in_last || hit_max) ? TAIL : DATA;
            end
         end
         TAIL: begin
            // Tail bits are zeros; three of them flush the shift register to 000.
            if (slot_free) begin
               load       = 1'b1;
               load_last  = (tail_cnt_q == 2'd2);
               sym_cnt_d  = sym_cnt_q + 10'd1;
               tail_cnt_d = tail_cnt_q + 2'd1;
               if (tail_cnt_q == 2'd2) begin
                  tail_cnt_d = 2'd0;
                  bit_cnt_d  = '0;
                  state_d    = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase

      win = {load_bit, s_q};
      if (load) begin
         d_out_d     = {^(win & G0), ^(win & G1)};
         s_d         = {load_bit, s_q[2:1]};
         out_valid_d = 1'b1;
         out_last_d  = load_last;
      end

      if (clear) begin
         state_d     = IDLE;
         s_d         = 3'd0;
         bit_cnt_d   = '0;
         tail_cnt_d  = 2'd0;
         sym_cnt_d   = 10'd0;
         out_valid_d = 1'b0;
         out_last_d  = 1'b0;
         d_out_d     = 2'b00;
         overflow_d  = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= IDLE;
         s_q         <= 3'd0;
         bit_cnt_q   <= '0;
         tail_cnt_q  <= 2'd0;
         sym_cnt_q   <= 10'd0;
         out_valid_q <= 1'b0;
         out_last_q  <= 1'b0;
         d_out_q     <= 2'b00;
         overflow_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         s_q         <= s_d;
         bit_cnt_q   <= bit_cnt_d;
         tail_cnt_q  <= tail_cnt_d;
         sym_cnt_q   <= sym_cnt_d;
         out_valid_q <= out_valid_d;
         out_last_q  <= out_last_d;
         d_out_q     <= d_out_d;
         overflow_q  <= overflow_d;
      end
   end

   assign in_ready  = in_ready_c;
   assign out_valid = out_valid_q;
   assign d_out     = d_out_q;
   assign out_last  = out_last_q;
   assign busy      = (state_q != IDLE);
   assign overflow  = overflow_q;
   assign sym_cnt   = sym_cnt_q;

endmodule

// File: tb/tb_conv_encoder.sv
// tb/tb_conv_encoder.sv - self-checking bench for conv_encoder
// Reference symbols come from a direct convolution sum over the frame's bit sequence.
module tb_conv_encoder;

   localparam logic [3:0] TB_G0   = 4'b1111;
   localparam logic [3:0] TB_G1   = 4'b1101;
   localparam int         TB_MAX  = 1021;

   logic       clk = 1'b0;
   logic       rst;
   logic       clear;
   logic       in_valid;
   logic       in_ready;
   logic       in_bit;
   logic       in_last;
   logic       out_valid;
   logic       out_ready;
   logic [1:0] d_out;
   logic       out_last;
   logic       busy;
   logic       overflow;
   logic [9:0] sym_cnt;

   conv_encoder #(.G0(TB_G0), .G1(TB_G1), .MAX_BITS(TB_MAX)) dut (
      .clk(clk), .rst(rst), .clear(clear),
      .in_valid(in_valid), .in_ready(in_ready), .in_bit(in_bit), .in_last(in_last),
      .out_valid(out_valid), .out_ready(out_ready), .d_out(d_out), .out_last(out_last),
      .busy(busy), .overflow(overflow), .sym_cnt(sym_cnt)
   );

   always #5 clk = ~clk;

   int         errors = 0;
   int         checks = 0;
   bit         data_q[$];
   bit         last_q[$];
   logic [2:0] got_q[$];
   logic [2:0] exp_q[$];
   int         acc_cnt;
   int         lasts_got;
   int         gaps;
   int         rdy_mode;
   logic [9:0] sym_at_last;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic load_vec(input logic [31:0] v, input int n, input bit with_last);
      data_q.delete();
      last_q.delete();
      for (int i = 0; i < n; i++) begin
         data_q.push_back(v[n-1-i]);
         last_q.push_back(with_last && (i == n - 1));
      end
   endtask

   task automatic load_rand(input int n, input bit with_last);
      data_q.delete();
      last_q.delete();
      for (int i = 0; i < n; i++) begin
         data_q.push_back(1'($urandom_range(0, 1)));
         last_q.push_back(with_last && (i == n - 1));
      end
   endtask

   // Symbol n of a frame is the mod-2 convolution of the zero-padded bits with each generator.
   task automatic add_exp(input int start, input int n_bits);
      for (int n = 0; n < n_bits + 3; n++) begin
         bit p0, p1, xb;
         p0 = 1'b0;
         p1 = 1'b0;
         for (int k = 0; k < 4; k++) begin
            xb = (n - k >= 0 && n - k < n_bits) ? data_q[start + n - k] : 1'b0;
            p0 = p0 ^ (TB_G0[3-k] & xb);
            p1 = p1 ^ (TB_G1[3-k] & xb);
         end
         exp_q.push_back({p0, p1, n == n_bits + 2});
      end
   endtask

   task automatic run(input int n_frames, input int budget);
      int   idx = 0;
      int   cyc = 0;
      logic stalled = 1'b0;
      logic [1:0] held = 2'b00;
      bit   first_seen = 1'b0;
      got_q.delete();
      exp_q.delete();
      lasts_got = 0;
      gaps = 0;
      while (lasts_got < n_frames && cyc < budget) begin
         @(negedge clk);
         if (stalled) check("stall_hold", 32'(d_out), 32'(held));
         case (rdy_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = (cyc % 3 == 0);
            default: out_ready = 1'($urandom_range(0, 1));
         endcase
         in_valid = (idx < data_q.size()) && !(out_valid && out_last && lasts_got == n_frames - 1);
         in_bit   = in_valid ? data_q[idx] : 1'b0;
         in_last  = in_valid ? last_q[idx] : 1'b0;
         #1;
         if (first_seen && !out_valid) gaps++;
         stalled = out_valid && !out_ready;
         if (stalled) begin
            held = d_out;
            check("stall_in_ready", 32'(in_ready), 32'd0);
         end
         if (out_valid && out_ready) begin
            got_q.push_back({d_out, out_last});
            first_seen = 1'b1;
            if (out_last) begin
               lasts_got++;
               sym_at_last = sym_cnt;
            end
         end
         if (in_valid && in_ready) idx++;
         cyc++;
      end
      in_valid = 1'b0;
      in_last  = 1'b0;
      acc_cnt  = idx;
      check("frames_done", 32'(lasts_got), 32'(n_frames));
   endtask

   task automatic compare(input string tag);
      int n;
      check({tag, "_len"}, 32'(got_q.size()), 32'(exp_q.size()));
      n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
      for (int i = 0; i < n; i++) check({tag, "_sym"}, 32'(got_q[i]), 32'(exp_q[i]));
   endtask

   task automatic push_two_bits();
      out_ready = 1'b1;
      @(negedge clk);
      in_valid = 1'b1; in_bit = 1'b1; in_last = 1'b0;
      @(negedge clk);
      in_bit = 1'b0;
      @(negedge clk);
      in_valid = 1'b0;
      check("abort_busy_before", 32'(busy), 32'd1);
   endtask

   initial begin
      rst = 1'b0; clear = 1'b0; in_valid = 1'b0; in_bit = 1'b0; in_last = 1'b0;
      out_ready = 1'b1; rdy_mode = 0;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      #1;
      check("rst_in_ready", 32'(in_ready), 32'd1);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_out_last", 32'(out_last), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_overflow", 32'(overflow), 32'd0);
      check("rst_d_out", 32'(d_out), 32'd0);
      check("rst_sym_cnt", 32'(sym_cnt), 32'd0);

      // Directed 1,0,1,1 frame at full rate
      load_vec(32'b1011, 4, 1'b1);
      run(1, 100);
      add_exp(0, 4);
      compare("f1011");
      check("f1011_sym_last", 32'(sym_at_last), 32'd7);
      @(negedge clk);
      check("f1011_busy_after", 32'(busy), 32'd0);
      check("f1011_valid_after", 32'(out_valid), 32'd0);

      // Impulse response
      load_vec(32'b1, 1, 1'b1);
      run(1, 100);
      add_exp(0, 1);
      compare("impulse");
      check("impulse_sym_last", 32'(sym_at_last), 32'd4);

      // Backpressure pattern
      rdy_mode = 1;
      load_vec(32'b1011, 4, 1'b1);
      run(1, 200);
      add_exp(0, 4);
      compare("bp");

      // Forced termination at MAX_BITS
      rdy_mode = 0;
      load_rand(1030, 1'b0);
      run(1, 3000);
      add_exp(0, TB_MAX);
      compare("ovf");
      check("ovf_accepted", 32'(acc_cnt), 32'(TB_MAX));
      check("ovf_flag", 32'(overflow), 32'd1);
      check("ovf_sym_wrap", 32'(sym_at_last), 32'd0);
      load_rand(3, 1'b1);
      run(1, 100);
      add_exp(0, 3);
      compare("ovf_next");
      check("ovf_cleared", 32'(overflow), 32'd0);

      // Back-to-back frames
      load_rand(8, 1'b0);
      last_q[3] = 1'b1;
      last_q[7] = 1'b1;
      run(2, 100);
      add_exp(0, 4);
      add_exp(4, 4);
      compare("b2b");
      check("b2b_gaps", 32'(gaps), 32'd0);

      // Random frames with random backpressure
      rdy_mode = 2;
      for (int f = 0; f < 6; f++) begin
         int n;
         n = $urandom_range(1, 24);
         load_rand(n, 1'b1);
         run(1, 500);
         add_exp(0, n);
         compare("rand");
         check("rand_sym_last", 32'(sym_at_last), 32'(n + 3));
      end
      rdy_mode = 0;

      // Asynchronous reset mid-frame
      push_two_bits();
      #2 rst = 1'b0;
      #1;
      check("arst_out_valid", 32'(out_valid), 32'd0);
      check("arst_busy", 32'(busy), 32'd0);
      @(negedge clk);
      rst = 1'b1;
      load_vec(32'b1011, 4, 1'b1);
      run(1, 100);
      add_exp(0, 4);
      compare("arst_f1011");

      // Synchronous clear mid-frame
      push_two_bits();
      clear = 1'b1;
      @(negedge clk);
      clear = 1'b0;
      check("clr_out_valid", 32'(out_valid), 32'd0);
      check("clr_busy", 32'(busy), 32'd0);
      check("clr_sym_cnt", 32'(sym_cnt), 32'd0);
      load_vec(32'b1011, 4, 1'b1);
      run(1, 100);
      add_exp(0, 4);
      compare("clr_f1011");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
